// File: rtl/lc3_isdu.sv
// LC-3 sequencer/decoder: Moore FSM driving datapath loads, bus gates, mux selects and memory strobes.
// Fetch+decode takes MEM_WAIT+4 cycles, no backpressure beyond the fixed memory wait; LC3_PAUSE_EN adds the PAUSE handshake states.
module lc3_isdu #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       run_i,
    input  logic       continue_i,
    input  logic [3:0] opcode_i,
    input  logic       ir_5_i,
    input  logic       ir_11_i,
    input  logic       ben_i,
    output logic       ld_mar_o,
    output logic       ld_mdr_o,
    output logic       ld_ir_o,
    output logic       ld_ben_o,
    output logic       ld_cc_o,
    output logic       ld_reg_o,
    output logic       ld_pc_o,
    output logic       gate_pc_o,
    output logic       gate_mdr_o,
    output logic       gate_alu_o,
    output logic       gate_marmux_o,
    output logic       drmux_o,
    output logic       sr1mux_o,
    output logic       sr2mux_o,
    output logic       addr1mux_o,
    output logic       mio_en_o,
    output logic [1:0] pcmux_o,
    output logic [1:0] addr2mux_o,
    output logic [1:0] aluk_o,
    output logic       mem_oe_o,
    output logic       mem_we_o,
    output logic       halted_o
);

    typedef enum logic [4:0] {
        S_HALTED, S_F1, S_F2, S_F3, S_DECODE,
        S_ALU, S_BR_T, S_JMP, S_JSR1, S_JSR2,
        S_LDR1, S_LDR2, S_LDR3, S_STR1, S_STR2, S_STR3,
        S_P1, S_P2
    } state_t;

    localparam logic [3:0] WAIT_C = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_done;

    assign mem_done = (cnt_q == WAIT_C);

`ifndef LC3_PAUSE_EN
    logic continue_unused;
    assign continue_unused = continue_i;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_HALTED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        // counter rests at zero outside memory states, so every entry starts cleared
        cnt_d         = '0;
        ld_mar_o      = 1'b0;
        ld_mdr_o      = 1'b0;
        ld_ir_o       = 1'b0;
        ld_ben_o      = 1'b0;
        ld_cc_o       = 1'b0;
        ld_reg_o      = 1'b0;
        ld_pc_o       = 1'b0;
        gate_pc_o     = 1'b0;
        gate_mdr_o    = 1'b0;
        gate_alu_o    = 1'b0;
        gate_marmux_o = 1'b0;
        drmux_o       = 1'b0;
        sr1mux_o      = 1'b0;
        sr2mux_o      = 1'b0;
        addr1mux_o    = 1'b0;
        mio_en_o      = 1'b0;
        pcmux_o       = 2'b00;
        addr2mux_o    = 2'b00;
        aluk_o        = 2'b00;
        mem_oe_o      = 1'b0;
        mem_we_o      = 1'b0;
        halted_o      = 1'b0;

        case (state_q)
            S_HALTED: begin
                halted_o = 1'b1;
                if (run_i) state_d = S_F1;
            end
            S_F1: begin
                gate_pc_o = 1'b1;
                ld_mar_o  = 1'b1;
                ld_pc_o   = 1'b1;
                state_d   = S_F2;
            end
            S_F2, S_LDR2: begin
                mem_oe_o = 1'b1;
                mio_en_o = 1'b1;
                if (mem_done) begin
                    ld_mdr_o = 1'b1;
                    state_d  = (state_q == S_F2) ? S_F3 : S_LDR3;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_F3: begin
                gate_mdr_o = 1'b1;
                ld_ir_o    = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                ld_ben_o = 1'b1;
                case (opcode_i)
                    4'b0001, 4'b0101, 4'b1001: state_d = S_ALU;
                    4'b0000: state_d = ben_i ? S_BR_T : S_F1;
                    4'b1100: state_d = S_JMP;
                    4'b0100: state_d = S_JSR1;
                    4'b0110: state_d = S_LDR1;
                    4'b0111: state_d = S_STR1;
`ifdef LC3_PAUSE_EN
                    4'b1101: state_d = S_P1;
`endif
                    default: state_d = S_F1;
                endcase
            end
            S_ALU: begin
                sr1mux_o   = 1'b1;
                sr2mux_o   = ir_5_i;
                case (opcode_i)
                    4'b0101: aluk_o = 2'b01;
                    4'b1001: aluk_o = 2'b10;
                    default: aluk_o = 2'b00;
                endcase
                gate_alu_o = 1'b1;
                ld_reg_o   = 1'b1;
                ld_cc_o    = 1'b1;
                state_d    = S_F1;
            end
            S_BR_T: begin
                addr2mux_o = 2'b10;
                pcmux_o    = 2'b10;
                ld_pc_o    = 1'b1;
                state_d    = S_F1;
            end
            S_JMP: begin
                sr1mux_o   = 1'b1;
                addr1mux_o = 1'b1;
                pcmux_o    = 2'b10;
                ld_pc_o    = 1'b1;
                state_d    = S_F1;
            end
            S_JSR1: begin
                gate_pc_o = 1'b1;
                drmux_o   = 1'b1;
                ld_reg_o  = 1'b1;
                state_d   = S_JSR2;
            end
            S_JSR2: begin
                pcmux_o = 2'b10;
                ld_pc_o = 1'b1;
                // JSR: PC + SEXT11; JSRR: base register from IR[8:6]
                if (ir_11_i) begin
                    addr2mux_o = 2'b11;
                end else begin
                    sr1mux_o   = 1'b1;
                    addr1mux_o = 1'b1;
                end
                state_d = S_F1;
            end
            S_LDR1, S_STR1: begin
                sr1mux_o      = 1'b1;
                addr1mux_o    = 1'b1;
                addr2mux_o    = 2'b01;
                gate_marmux_o = 1'b1;
                ld_mar_o      = 1'b1;
                state_d       = (state_q == S_LDR1) ? S_LDR2 : S_STR2;
            end
            S_LDR3: begin
                gate_mdr_o = 1'b1;
                ld_reg_o   = 1'b1;
                ld_cc_o    = 1'b1;
                state_d    = S_F1;
            end
            S_STR2: begin
                aluk_o     = 2'b11;
                gate_alu_o = 1'b1;
                ld_mdr_o   = 1'b1;
                state_d    = S_STR3;
            end
            S_STR3: begin
                mem_we_o = 1'b1;
                if (mem_done) state_d = S_F1;
                else          cnt_d   = cnt_q + 4'd1;
            end
`ifdef LC3_PAUSE_EN
            S_P1: begin
                halted_o = 1'b1;
                if (continue_i) state_d = S_P2;
            end
            S_P2: begin
                if (!continue_i) state_d = S_F1;
            end
`endif
            default: state_d = S_HALTED;
        endcase
    end

endmodule

// File: tb/tb_lc3_isdu.sv
// Scoreboard bench for lc3_isdu: two instances (MEM_WAIT=2 and MEM_WAIT=0) share stimulus.
module tb_lc3_isdu;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic       drmux, sr1mux, sr2mux, addr1mux, mio_en;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       mem_oe, mem_we, halted;
    } out_t;

    logic       clk = 1'b0;
    logic       reset, run, cont, ir5, ir11, ben;
    logic [3:0] opc;
    wire out_t  o2, o0;

    always #5 clk = ~clk;

`define ISDU_PORTS(OV) \
    .clk_i(clk), .reset_i(reset), .run_i(run), .continue_i(cont), .opcode_i(opc), \
    .ir_5_i(ir5), .ir_11_i(ir11), .ben_i(ben), \
    .ld_mar_o(OV.ld_mar), .ld_mdr_o(OV.ld_mdr), .ld_ir_o(OV.ld_ir), .ld_ben_o(OV.ld_ben), \
    .ld_cc_o(OV.ld_cc), .ld_reg_o(OV.ld_reg), .ld_pc_o(OV.ld_pc), \
    .gate_pc_o(OV.gate_pc), .gate_mdr_o(OV.gate_mdr), .gate_alu_o(OV.gate_alu), \
    .gate_marmux_o(OV.gate_marmux), .drmux_o(OV.drmux), .sr1mux_o(OV.sr1mux), \
    .sr2mux_o(OV.sr2mux), .addr1mux_o(OV.addr1mux), .mio_en_o(OV.mio_en), \
    .pcmux_o(OV.pcmux), .addr2mux_o(OV.addr2mux), .aluk_o(OV.aluk), \
    .mem_oe_o(OV.mem_oe), .mem_we_o(OV.mem_we), .halted_o(OV.halted)

    lc3_isdu #(.MEM_WAIT(2)) u_w2 (`ISDU_PORTS(o2));
    lc3_isdu #(.MEM_WAIT(0)) u_w0 (`ISDU_PORTS(o0));

    out_t  exp_q[$];
    bit    sel_q[$];
    string nm_q[$];
    bit    cur_sel = 1'b0;
    int    n_vec = 0;
    int    n_bad = 0;

    // Monitor: compares one queued expectation per cycle, away from the rising edge
    always @(negedge clk) begin : monitor
        out_t  e, a;
        bit    s;
        string n;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            n = nm_q.pop_front();
            a = s ? o0 : o2;
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s (W=%0d): got %b expected %b", n, s ? 0 : 2, a, e);
            end
        end
    end

    function automatic out_t e_halt();
        out_t e = '0; e.halted = 1'b1; return e;
    endfunction
    function automatic out_t e_f1();
        out_t e = '0; e.gate_pc = 1'b1; e.ld_mar = 1'b1; e.ld_pc = 1'b1; return e;
    endfunction
    function automatic out_t e_rd(input bit last);
        out_t e = '0; e.mem_oe = 1'b1; e.mio_en = 1'b1; e.ld_mdr = last; return e;
    endfunction
    function automatic out_t e_f3();
        out_t e = '0; e.gate_mdr = 1'b1; e.ld_ir = 1'b1; return e;
    endfunction
    function automatic out_t e_dec();
        out_t e = '0; e.ld_ben = 1'b1; return e;
    endfunction
    function automatic out_t e_alu(input bit sr2, input logic [1:0] k);
        out_t e = '0;
        e.sr1mux = 1'b1; e.sr2mux = sr2; e.aluk = k;
        e.gate_alu = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
        return e;
    endfunction
    function automatic out_t e_pcadd(input bit a1, input logic [1:0] a2);
        out_t e = '0;
        e.sr1mux = a1; e.addr1mux = a1; e.addr2mux = a2; e.pcmux = 2'b10; e.ld_pc = 1'b1;
        return e;
    endfunction
    function automatic out_t e_jsr1();
        out_t e = '0; e.gate_pc = 1'b1; e.drmux = 1'b1; e.ld_reg = 1'b1; return e;
    endfunction
    function automatic out_t e_ea();
        out_t e = '0;
        e.sr1mux = 1'b1; e.addr1mux = 1'b1; e.addr2mux = 2'b01;
        e.gate_marmux = 1'b1; e.ld_mar = 1'b1;
        return e;
    endfunction
    function automatic out_t e_ldr3();
        out_t e = '0; e.gate_mdr = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1; return e;
    endfunction
    function automatic out_t e_str2();
        out_t e = '0; e.aluk = 2'b11; e.gate_alu = 1'b1; e.ld_mdr = 1'b1; return e;
    endfunction
    function automatic out_t e_we();
        out_t e = '0; e.mem_we = 1'b1; return e;
    endfunction

    task automatic chk(input string n, input out_t e);
        exp_q.push_back(e);
        sel_q.push_back(cur_sel);
        nm_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [3:0] op, input logic i5, input logic i11, input logic b);
        opc = op; ir5 = i5; ir11 = i11; ben = b;
    endtask

    task automatic fetch(input int w);
        chk("F1", e_f1());
        for (int i = 0; i <= w; i++) chk("F2", e_rd(i == w));
        chk("F3", e_f3());
        chk("DECODE", e_dec());
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; cont = 1'b0;
        set_ir(4'b0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        // Reset dominates Run
        chk("RESET0", e_halt());
        chk("RESET1", e_halt());
        reset = 1'b0;
        chk("HALT_RUN", e_halt());
        run = 1'b0;

        set_ir(4'b0001, 1'b1, 1'b0, 1'b0);
        fetch(2); chk("ADD_IMM", e_alu(1'b1, 2'b00));
        cont = 1'b1;
        set_ir(4'b0101, 1'b0, 1'b0, 1'b0);
        fetch(2); chk("AND_REG", e_alu(1'b0, 2'b01));
        cont = 1'b0;
        set_ir(4'b1001, 1'b0, 1'b0, 1'b0);
        fetch(2); chk("NOT", e_alu(1'b0, 2'b10));
        set_ir(4'b0000, 1'b0, 1'b0, 1'b0);
        fetch(2);
        set_ir(4'b0000, 1'b0, 1'b0, 1'b1);
        fetch(2); chk("BR_T", e_pcadd(1'b0, 2'b10));
        set_ir(4'b1100, 1'b0, 1'b0, 1'b0);
        fetch(2); chk("JMP", e_pcadd(1'b1, 2'b00));
        set_ir(4'b0100, 1'b0, 1'b0, 1'b0);
        fetch(2); chk("JSRR1", e_jsr1()); chk("JSRR2", e_pcadd(1'b1, 2'b00));
        set_ir(4'b0100, 1'b0, 1'b1, 1'b0);
        fetch(2); chk("JSR1", e_jsr1()); chk("JSR2", e_pcadd(1'b0, 2'b11));
        set_ir(4'b0110, 1'b0, 1'b0, 1'b0);
        fetch(2); chk("LDR1", e_ea());
        for (int i = 0; i <= 2; i++) chk("LDR2", e_rd(i == 2));
        chk("LDR3", e_ldr3());
        // Unimplemented opcode is a NOP; Run outside HALTED is ignored
        run = 1'b1;
        set_ir(4'b1000, 1'b0, 1'b0, 1'b0);
        fetch(2);
        run = 1'b0;

        set_ir(4'b1101, 1'b0, 1'b0, 1'b0);
        fetch(2);
`ifdef LC3_PAUSE_EN
        for (int i = 0; i < 10; i++) chk("P1_HOLD", e_halt());
        cont = 1'b1;
        chk("P1_PRESS", e_halt());
        chk("P2_HOLD", '0);
        chk("P2_HOLD", '0);
        cont = 1'b0;
        chk("P2_RELEASE", '0);
`endif

        set_ir(4'b0111, 1'b0, 1'b0, 1'b0);
        fetch(2); chk("STR1", e_ea()); chk("STR2", e_str2());
        for (int i = 0; i <= 2; i++) chk("STR3", e_we());
        fetch(2); chk("STR1", e_ea()); chk("STR2", e_str2());
        chk("STR3", e_we());
        // Reset mid-write: strobe must be gone on the next cycle
        reset = 1'b1;
        chk("STR3_RST", e_we());
        reset = 1'b0;
        chk("RST_MIDWR", e_halt());
        chk("STAY_HALT", e_halt());

        // Zero-wait instance
        cur_sel = 1'b1;
        reset = 1'b1;
        chk("W0_RESET", e_halt());
        reset = 1'b0; run = 1'b1;
        chk("W0_HALT_RUN", e_halt());
        run = 1'b0;
        set_ir(4'b0001, 1'b0, 1'b0, 1'b0);
        fetch(0); chk("W0_ADD", e_alu(1'b0, 2'b00));
        set_ir(4'b0111, 1'b0, 1'b0, 1'b0);
        fetch(0); chk("W0_STR1", e_ea()); chk("W0_STR2", e_str2());
        chk("W0_STR3", e_we());
        chk("W0_F1", e_f1());

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lc3_isdu.md
# lc3_isdu

Instruction sequence/decode unit for the LC-3 core. It is a Moore state machine that drives every load, gate and mux-select input of the datapath, plus the memory strobes, to run fetch, decode and execute. It sits beside the datapath and takes the opcode, selected IR bits and BEN back from it. Memory accesses use a parameterised fixed wait count.

## Interface
- MEM_WAIT, 2, extra wait cycles per memory access (0..15)
- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; forces HALTED
- Run  in  1  leaves HALTED
- Continue  in  1  resume handshake for PAUSE
- Opcode  in  4  IR[15:12]
- IR_5  in  1  immediate flag for ADD/AND
- IR_11  in  1  JSR/JSRR flag
- BEN  in  1  branch enable from datapath
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC  out  1 each  register loads
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN  out  1 each  selects
- PCMUX, ADDR2MUX, ALUK  out  2 each  selects
- Mem_OE, Mem_WE  out  1 each  memory read/write strobes, active-high
- halted  out  1  high in HALTED

## Operation
- Select encodings:
  - PCMUX: 00=PC+1, 01=bus, 10=adder.
  - ADDR2MUX: 00=0, 01=SEXT6, 10=SEXT9, 11=SEXT11.
  - ADDR1MUX: 0=PC, 1=SR1.
  - SR1MUX: 0=IR[11:9], 1=IR[8:6].
  - SR2MUX: 0=reg, 1=SEXT5.
  - DRMUX: 0=IR[11:9], 1=R7.
  - ALUK: 00=ADD, 01=AND, 10=NOT A, 11=pass A.
  - MIO_EN: 1=memory data into MDR.
- All outputs default 0; each state raises only the outputs listed for it.
- HALTED: halted=1. Run=1 moves to F1; otherwise stay.
- F1: GatePC, LD_MAR, PCMUX=00, LD_PC.
- F2 (read): Mem_OE, MIO_EN. LD_MDR only in the last of MEM_WAIT+1 cycles.
- F3: GateMDR, LD_IR.
- DECODE: LD_BEN. Next state by Opcode:
  - ADD 0001, AND 0101, NOT 1001 → ALU.
  - BR 0000 → BR_T if BEN=1, else F1.
  - JMP 1100 → JMP.
  - JSR 0100 → JSR1.
  - LDR 0110 → LDR1.
  - STR 0111 → STR1.
  - PAUSE 1101 → see Configuration.
  - All other opcodes → F1 (executed as NOP).
- ALU: SR1MUX=1, SR2MUX=IR_5, ALUK per opcode, GateALU, DRMUX=0, LD_REG, LD_CC → F1.
- BR_T: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC → F1.
- JMP: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC → F1.
- JSR1: GatePC, DRMUX=1, LD_REG → JSR2.
- JSR2: PCMUX=10, LD_PC. If IR_11=1: ADDR1MUX=0, ADDR2MUX=11. If IR_11=0: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00. Next F1.
- LDR1: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR.
- LDR2: read exactly as F2.
- LDR3: GateMDR, DRMUX=0, LD_REG, LD_CC → F1.
- STR1: same outputs as LDR1.
- STR2: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR.
- STR3: Mem_WE for MEM_WAIT+1 cycles → F1.
- Wait counter: 4-bit. Cleared on entry to every memory state; counts up; the state exits when the counter equals MEM_WAIT. With MEM_WAIT=0, a memory state lasts 1 cycle.

## Timing
- Reset: state=HALTED, counter=0. All outputs 0 except halted=1.
- Reset=1 overrides everything, including mid-access. Strobes drop on the next edge and no write completes.
- Run is ignored outside HALTED. Continue is ignored outside the pause states.
- Cycles per instruction, with W=MEM_WAIT:
  - Fetch+decode: W+4.
  - ALU, JMP, BR taken: +1.
  - BR not taken: +0.
  - JSR: +2.
  - LDR, STR: +W+3.
- No HALTED return except via Reset (or the PAUSE path).

## Configuration
- LC3_PAUSE_EN defined:
  - Opcode 1101 → P1, with halted=1.
  - P1 holds while Continue=0, then goes to P2.
  - P2 holds while Continue=1, then goes to F1.
  - Net effect: one full press/release of Continue per PAUSE.
- Undefined: 1101 is a NOP (DECODE→F1). P1/P2 are not synthesised.

## Test plan
- Reset=1 for 2 cycles with Run=1 → halted=1, all other outputs 0. Release Reset, pulse Run → F1 shows GatePC=LD_MAR=LD_PC=1 on the next cycle.
- MEM_WAIT=2, Opcode=0001, IR_5=1 → Mem_OE high exactly 3 cycles; LD_MDR only in the 3rd. Next F1 occurs 7 cycles after the previous F1. The ALU cycle shows SR2MUX=1, ALUK=00, LD_REG=LD_CC=1.
- Opcode=0000 with BEN=0, then with BEN=1 → 6-cycle and 7-cycle instruction periods. The taken case shows PCMUX=10, ADDR2MUX=10.
- Opcode=0100, IR_11=0 → JSR1 shows DRMUX=1, GatePC, LD_REG. JSR2 shows ADDR1MUX=1, ADDR2MUX=00, PCMUX=10.
- Opcode=0111, MEM_WAIT=0 → STR2 shows ALUK=11, LD_MDR, MIO_EN=0. Mem_WE high exactly 1 cycle. Assert Reset during STR3 with MEM_WAIT=5 → Mem_WE=0 and halted=1 next cycle.
- With LC3_PAUSE_EN, Opcode=1101 → halted=1 and stays in P1 for 10 cycles with Continue=0. Continue=1 for 3 cycles → held in P2. Continue=0 → F1 next cycle. Without the macro, the same opcode takes 6 cycles (fetch+decode) at MEM_WAIT=2.
